tone_selector: RTL

TONE_SELECTOR -- requirements
Module: tone_selector

---
 rtl/tone_selector.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tone_selector.sv
// Single-voice piano tone selector: synchronizes and debounces eight keys,
// latches the highest-priority note for a minimum hold time, gates its tone to the speaker.
`timescale 1ns/1ps
module tone_selector #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MIN_HOLD_CYCLES = 5000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] KEY,
    input  logic [7:0] TONE,
    output logic       SPEAKER,
    output logic [2:0] NOTE_IDX,
    output logic       PLAYING
);

    localparam int unsigned NKEYS  = 8;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (MIN_HOLD_CYCLES > 0) ? $clog2(MIN_HOLD_CYCLES + 1) : 1;
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    logic [NKEYS-1:0] r_key_meta;
    logic [NKEYS-1:0] r_key_sync;
    logic [NKEYS-1:0] r_key_db;
    logic [DB_W-1:0]  r_db_cnt [NKEYS];

    state_t           r_state;
    logic [2:0]       r_note_idx;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic             r_playing;
    logic             r_speaker;

    logic             w_sel_valid;
    logic [2:0]       w_sel;
    logic             w_hold_met;
    state_t           w_state_nxt;
    logic [2:0]       w_note_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;

    // Key synchronizer and per-key debounce counters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_key_meta <= '0;
            r_key_sync <= '0;
            r_key_db   <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_key_meta <= KEY;
            r_key_sync <= r_key_meta;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                if (r_key_sync[i] == r_key_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_key_db[i] <= ~r_key_db[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Fixed priority: lowest set index (C4) wins.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = '0;
        for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
            if (r_key_db[i]) begin
                w_sel_valid = 1'b1;
                w_sel       = 3'(i);
            end
        end
    end

    assign w_hold_met = (r_hold_cnt == HOLD_MAX);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, note latch and hold counter; a note cannot stop or change before the hold is met.
    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note_idx;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt = S_PLAY;
                    w_note_nxt  = w_sel;
                    w_hold_nxt  = '0;
                end
            end
            S_PLAY: begin
                if (!w_hold_met) begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end else if (!w_sel_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sel != r_note_idx) begin
                    w_note_nxt = w_sel;
                    w_hold_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_note_idx <= '0;
            r_hold_cnt <= '0;
            r_playing  <= 1'b0;
            r_speaker  <= 1'b0;
        end else begin
            r_note_idx <= w_note_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_playing  <= (w_state_nxt == S_PLAY);
            r_speaker  <= (r_state == S_PLAY) ? TONE[r_note_idx] : 1'b0;
        end
    end

    assign SPEAKER  = r_speaker;
    assign NOTE_IDX = r_note_idx;
    assign PLAYING  = r_playing;

endmodule
